fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, the fetch-buffer entry count; only the value 2 is supported.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 stall_f  input  1  hazard unit stall; when 1 the head entry SHALL NOT be consumed.
REQ-006 branch_taken  input  1  redirect request from execute.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  32  request address (word aligned).
REQ-010 imem_gnt  input  1  memory accepts request; a handshake completes when imem_req and imem_gnt are both 1.
REQ-011 imem_rvalid  input  1  read data valid, 1 or more cycles after handshake.
REQ-012 imem_rdata  input  32  read instruction.
REQ-013 valid_f  output  1  head entry present.
REQ-014 instr_f, pc_f, pc_plus4_f  output  32 each  head instruction, its address, address+4; feed the IF/ID pipeline register.

Function
REQ-015 The block SHALL keep fetch_pc, the next request address, advancing by 4 (mod 2^32, wrap to 0) on each handshake.
REQ-016 The block SHALL allow at most one outstanding request.
REQ-017 The FSM SHALL have states IDLE (none outstanding), WAIT (outstanding, response kept) and DRAIN (outstanding, response discarded).
REQ-018 imem_req SHALL be 1 only in IDLE with buffer count < BUF_DEPTH and branch_taken = 0; imem_addr SHALL equal fetch_pc.
REQ-019 IDLE -> WAIT on handshake; WAIT -> IDLE on imem_rvalid; DRAIN -> IDLE on imem_rvalid.
REQ-020 In WAIT, imem_rvalid with branch_taken = 0 SHALL push {rdata, address} into the buffer.
REQ-021 The block SHALL compute pc_plus4_f as pc_f + 4 (mod 2^32).
REQ-022 branch_taken SHALL, in the same edge: load fetch_pc with branch_target, empty the buffer, and move WAIT -> DRAIN.
REQ-023 branch_taken in WAIT coincident with imem_rvalid SHALL discard the data and go to IDLE.
REQ-024 branch_taken in DRAIN SHALL reload fetch_pc and remain in DRAIN, or go to IDLE if imem_rvalid is also 1.
REQ-025 branch_taken in IDLE SHALL suppress that cycle's request; the first request to branch_target SHALL issue the next cycle.
REQ-026 branch_taken SHALL override stall_f.
REQ-027 The head SHALL be popped when valid_f = 1, stall_f = 0 and branch_taken = 0.
REQ-028 Simultaneous push and pop SHALL leave the count unchanged.
REQ-029 Push when full SHALL be impossible by REQ-018; a bench assertion SHALL flag it.
REQ-030 valid_f SHALL equal (count != 0); when count = 0, instr_f, pc_f and pc_plus4_f SHALL be 0.
REQ-031 The block SHALL ignore imem_rvalid in IDLE.
REQ-032 Minimum latency, handshake to valid_f, SHALL be memory latency + 1 cycle (registered buffer).

Reset
REQ-033 While rst = 0, the block SHALL hold: state IDLE, fetch_pc = RESET_PC, count = 0, pointers 0, imem_req = 0, valid_f = 0, instr_f/pc_f/pc_plus4_f = 0.
REQ-034 Reset mid-request SHALL drop the outstanding transaction; an imem_rvalid after reset release SHALL be ignored (IDLE).
REQ-035 The first request after reset release SHALL be to RESET_PC, on the first clock edge with rst = 1.

Structure
REQ-036 Shared package/header fetch_defs SHALL hold FSM state encodings, the instruction width (32) and the PC increment (4).
REQ-037 The buffer SHALL be sub-module fetch_fifo (BUF_DEPTH entries of 64 bits {pc, instr}, with push, pop, flush, count).
REQ-038 FSM and fetch_pc SHALL live in fetch_unit; no combinational path from imem_rdata to imem_req.

Verification
REQ-039 Reset release, gnt = 1, 1-cycle rdata -> requests to 0x0, 0x4, 0x8; valid_f with pc_f = 0x0, pc_plus4_f = 0x4.
REQ-040 stall_f = 1 for 5 cycles -> count reaches 2, imem_req = 0, head stays pc_f = 0x0; release -> 0x4 follows next cycle.
REQ-041 branch_taken with target 0x100 while WAIT on 0x8 -> that response is discarded, buffer empty, next request 0x100, next valid pc_f = 0x100.
REQ-042 branch_taken coincident with imem_rvalid -> data not pushed, state IDLE, next imem_addr = target.
REQ-043 fetch_pc = 0xFFFF_FFFC handshake -> next imem_addr = 0x0, pc_plus4_f = 0x0.
REQ-044 rst asserted in WAIT, then a late imem_rvalid -> no push, valid_f = 0, next request at RESET_PC.

Source files
------------

// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - FSM state encodings (IDLE / WAIT / DRAIN)
//   - instruction and PC widths, PC increment
//   - fetch_entry_t: one fetch-buffer entry {pc, instr}
//   - pc_next(): wrapping PC increment used by the fetch PC and pc_plus4_f
package fetch_defs;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;  // no request outstanding
    localparam logic [1:0] ST_WAIT  = 2'd1;  // outstanding, response will be kept
    localparam logic [1:0] ST_DRAIN = 2'd2;  // outstanding, response will be discarded

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Address arithmetic wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0x0).
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: small circular FIFO of {pc, instr} entries.
//   clk, rst   : clock, asynchronous active-low reset (pointers/count only)
//   push/wdata : write one entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the buffer; wins over push and pop
//   head       : head entry, all-zero when the buffer is empty
//   count      : number of valid entries
module fetch_fifo
    import fetch_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_entry_t       mem_p1 [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push && (count != FULL);
    assign do_pop  = pop  && (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= ptr_inc(wptr);
            if (do_pop)  rptr <= ptr_inc(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_p1[wptr] <= wdata;
    end

    assign head = (count != '0) ? mem_p1[rptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// buffers responses in a 2-entry FIFO and presents the head to IF/ID.
//   clk, rst                   : clock, asynchronous active-low reset
//   stall_f                    : hold the head entry
//   branch_taken/branch_target : redirect; flushes buffer, drops in-flight data
//   imem_req/imem_addr/imem_gnt: request handshake (req & gnt)
//   imem_rvalid/imem_rdata     : response, >= 1 cycle after handshake
//   valid_f, instr_f, pc_f, pc_plus4_f : head entry (zeros when empty)
module fetch_unit
    import fetch_defs::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_f,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [31:0]        fetch_pc;
    logic [31:0]        req_pc_p0;
    logic               hs;
    logic               fifo_push;
    logic               fifo_pop;
    logic [CNT_W-1:0]   count;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

    // Request only from IDLE with buffer room; a redirect cycle never requests
    // so the first request to the new target lands on the following cycle.
    // Gated by rst so the request stays low throughout reset.
    assign imem_req  = rst && (state == ST_IDLE) && (count < FULL) && !branch_taken;
    assign imem_addr = fetch_pc;
    assign hs        = imem_req && imem_gnt;

    // Responses are taken only in WAIT; in IDLE a stray rvalid is ignored.
    assign fifo_push = (state == ST_WAIT) && imem_rvalid && !branch_taken;
    assign fifo_pop  = valid_f && !stall_f && !branch_taken;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (hs) state_nxt = ST_WAIT;
            ST_WAIT:  begin
                if (imem_rvalid)       state_nxt = ST_IDLE;
                else if (branch_taken) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (imem_rvalid) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (branch_taken)
                fetch_pc <= branch_target;
            else if (hs)
                fetch_pc <= pc_next(fetch_pc);
        end
    end

    // Address of the outstanding request, paired with its response on push.
    always_ff @(posedge clk) begin
        if (hs) req_pc_p0 <= fetch_pc;
    end

    assign push_entry = '{pc: req_pc_p0, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .flush (branch_taken),
        .head  (head),
        .count (count)
    );

    assign valid_f    = (count != '0);
    assign instr_f    = head.instr;
    assign pc_f       = head.pc;
    assign pc_plus4_f = valid_f ? pc_next(head.pc) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a negedge monitor models the memory,
// tracks the expected request address and a scoreboard of buffered entries;
// the main sequence walks the reset, stall, redirect and wrap cases.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        valid_f;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_f       (stall_f),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .valid_f       (valid_f),
        .instr_f       (instr_f),
        .pc_f          (pc_f),
        .pc_plus4_f    (pc_plus4_f)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] target;
        int          lat;
        bit          stall;
        logic [31:0] nxt;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] hs_log[$];
    int          tests = 0;
    int          fails = 0;
    bit          pend = 1'b0;
    bit          outst = 1'b0;
    bit          discard = 1'b0;
    int          cnt = 0;
    int          lat = 1;
    logic [31:0] paddr = 32'h0;
    logic [31:0] exp_pc = RST_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model + scoreboard, evaluated away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req",   {31'b0, imem_req}, 32'd0);
            chk("rst_valid", {31'b0, valid_f},  32'd0);
            chk("rst_instr", instr_f,    32'd0);
            chk("rst_pc",    pc_f,       32'd0);
            chk("rst_pc4",   pc_plus4_f, 32'd0);
            sb.delete();
            outst   = 1'b0;
            discard = 1'b0;
            exp_pc  = RST_PC;
        end else begin
            chk("valid_f", {31'b0, valid_f}, {31'b0, (sb.size() != 0)});
            if (sb.size() != 0) begin
                chk("head_pc",    pc_f,       sb[0].pc);
                chk("head_instr", instr_f,    sb[0].instr);
                chk("head_pc4",   pc_plus4_f, sb[0].pc + 32'd4);
            end else begin
                chk("empty_pc",    pc_f,       32'd0);
                chk("empty_instr", instr_f,    32'd0);
                chk("empty_pc4",   pc_plus4_f, 32'd0);
            end
            if (imem_req) begin
                chk("imem_addr", imem_addr, exp_pc);
                chk("req_legal", {31'b0, (!branch_taken && !outst && sb.size() < 2)}, 32'd1);
            end
            if (dut.fifo_push)
                chk("push_not_full", {31'b0, (dut.u_fifo.count < 2'd2)}, 32'd1);
            if (branch_taken) begin
                sb.delete();
                if (outst) discard = 1'b1;
            end else if (valid_f && !stall_f && sb.size() != 0) begin
                void'(sb.pop_front());
            end
        end

        imem_rvalid = 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(paddr);
                pend        = 1'b0;
                if (rst && outst && !discard && !branch_taken)
                    sb.push_back('{pc: paddr, instr: mem_word(paddr)});
                outst = 1'b0;
            end else begin
                cnt--;
            end
        end

        if (rst && imem_req && imem_gnt) begin
            hs_log.push_back(imem_addr);
            pend    = 1'b1;
            cnt     = lat;
            paddr   = imem_addr;
            outst   = 1'b1;
            discard = 1'b0;
        end
        if (rst) begin
            if (branch_taken)              exp_pc = branch_target;
            else if (imem_req && imem_gnt) exp_pc = exp_pc + 32'd4;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req) begin ok = 1'b1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (valid_f) begin ok = 1'b1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_hs(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin ok = 1'b1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic branch(input logic [31:0] t);
        branch_target = t;
        branch_taken  = 1'b1;
        step();
        branch_taken  = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{target: 32'h0000_0300, lat: 1, stall: 1'b0, nxt: 32'h0000_0304};
        vecs[1] = '{target: 32'hFFFF_FFFC, lat: 2, stall: 1'b0, nxt: 32'h0000_0000};
        vecs[2] = '{target: 32'h7FFF_FFF8, lat: 3, stall: 1'b1, nxt: 32'h7FFF_FFFC};
        vecs[3] = '{target: 32'h1234_5670, lat: 1, stall: 1'b1, nxt: 32'h1234_5674};

        rst           = 1'b0;
        stall_f       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_gnt      = 1'b1;
        lat           = 1;
        repeat (3) @(posedge clk);
        #1;

        // Reset release with the consumer stalled: buffer fills to two.
        stall_f = 1'b1;
        rst     = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk("stall_valid", {31'b0, valid_f}, 32'd1);
        chk("stall_pc",    pc_f,       32'h0);
        chk("stall_pc4",   pc_plus4_f, 32'h4);
        chk("stall_instr", instr_f,    mem_word(32'h0));
        chk("stall_noreq", {31'b0, imem_req}, 32'd0);
        chk("count_full",  {30'b0, dut.u_fifo.count}, 32'd2);

        step();
        lat     = 3;
        stall_f = 1'b0;
        @(negedge clk);
        chk("release_pc0", pc_f, 32'h0);
        step();
        @(negedge clk);
        chk("release_pc4", pc_f, 32'h4);

        // Redirect while waiting on 0x8.
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (imem_req && imem_addr == 32'h8) begin found = 1'b1; break; end
                @(negedge clk);
            end
            chk("req8_seen", {31'b0, found}, 32'd1);
        end
        step();
        branch(32'h0000_0100);
        @(negedge clk);
        chk("redir_empty", {31'b0, valid_f}, 32'd0);
        chk("hs0", (hs_log.size() > 0) ? hs_log[0] : 32'hDEAD_DEAD, 32'h0);
        chk("hs1", (hs_log.size() > 1) ? hs_log[1] : 32'hDEAD_DEAD, 32'h4);
        chk("hs2", (hs_log.size() > 2) ? hs_log[2] : 32'hDEAD_DEAD, 32'h8);
        wait_req("redir_req");
        chk("redir_addr", imem_addr, 32'h100);
        wait_valid("redir_valid");
        chk("redir_pc",  pc_f,       32'h100);
        chk("redir_pc4", pc_plus4_f, 32'h104);

        // Redirect on the same cycle as the response.
        lat = 2;
        wait_hs("coinc_hs");
        step();
        step();
        branch(32'h0000_0200);
        @(negedge clk);
        chk("coinc_req",   {31'b0, imem_req}, 32'd1);
        chk("coinc_addr",  imem_addr, 32'h200);
        chk("coinc_empty", {31'b0, valid_f}, 32'd0);
        wait_valid("coinc_valid");
        chk("coinc_pc", pc_f, 32'h200);

        // Table of redirects, including the address wrap and stall override.
        for (int v = 0; v < 4; v++) begin
            int base;
            step();
            lat     = vecs[v].lat;
            stall_f = vecs[v].stall;
            base    = hs_log.size();
            branch(vecs[v].target);
            stall_f = 1'b0;
            wait_valid("vec_valid");
            chk("vec_pc",    pc_f,       vecs[v].target);
            chk("vec_pc4",   pc_plus4_f, vecs[v].nxt);
            chk("vec_instr", instr_f,    mem_word(vecs[v].target));
            begin
                bit ok = 1'b0;
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    if (hs_log.size() >= base + 2) begin ok = 1'b1; break; end
                end
                if (!ok) chk("vec_hs_timeout", 32'd0, 32'd1);
                else begin
                    chk("vec_hs_first", hs_log[base],     vecs[v].target);
                    chk("vec_hs_next",  hs_log[base + 1], vecs[v].nxt);
                end
            end
        end

        // Reset while a request is outstanding; the late response is ignored.
        step();
        lat = 4;
        wait_hs("rstmid_hs");
        step();
        rst      = 1'b0;
        imem_gnt = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid_valid", {31'b0, valid_f}, 32'd0);
            chk("rstmid_req",   {31'b0, imem_req}, 32'd1);
            chk("rstmid_addr",  imem_addr, RST_PC);
            step();
        end
        imem_gnt = 1'b1;
        wait_valid("rstmid_rvalid");
        chk("rstmid_pc",    pc_f,    RST_PC);
        chk("rstmid_instr", instr_f, mem_word(RST_PC));

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (tests=%0d)", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
